// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Push-button stopwatch driving six active-low 7-segment digits as MM:SS:CC.
//   The button is synchronised and debounced into a one-cycle press pulse.
//   sw[0] selects what a press does (0 = start/stop, 1 = lap/clear) and
//   sw[1] holds the whole block cleared in IDLE.
//
// Ports
//   clk_clk        system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   button_n       raw push-button, low = pressed (asynchronous)
//   sw[1:0]        raw slide switches (asynchronous): [0] function, [1] hold-clear
//   hex0..hex5     active-low segments {g,f,e,d,c,b,a}
//                  hex5/hex4 = minutes, hex3/hex2 = seconds, hex1/hex0 = centiseconds
//   running        high in RUN or LAP
//   lap_active     high in LAP
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,  // clock cycles per centisecond, >= 2
    parameter int DB_CYCLES = 500000   // stable samples to accept a button level, >= 1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       button_n,
    input  logic [1:0] sw,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       running,
    output logic       lap_active
);

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic       btn_meta, btn_sync;
    logic [1:0] sw_meta, sw_sync;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            // NOTE: the button chain resets to the released level (1) so that
            // leaving reset can never look like a press.
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            sw_meta  <= 2'b00;
            sw_sync  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the value its
            // neighbour held before the edge, which is what makes this a chain.
            btn_meta <= button_n;
            btn_sync <= btn_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce and press pulse
    // ------------------------------------------------------------------
    logic          db_level;   // accepted button level
    logic          db_last;    // db_level one cycle earlier
    logic [DW-1:0] db_cnt;     // consecutive samples differing from db_level
    logic          press;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_level <= 1'b1;
            db_last  <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            db_last <= db_level;
            press   <= db_last & ~db_level;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    logic clear, press_ss, press_lap;
    assign clear     = sw_sync[1];
    assign press_ss  = press & ~sw_sync[0];
    assign press_lap = press &  sw_sync[0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;

    always_comb begin
        // NOTE: every path starts from the hold value, so no latch is inferred.
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (press_ss) state_d = S_RUN;
                S_RUN:   if (press_ss) state_d = S_PAUSE;
                         else if (press_lap) state_d = S_LAP;
                S_LAP:   if (press_ss) state_d = S_PAUSE;
                         else if (press_lap) state_d = S_RUN;
                S_PAUSE: if (press_ss) state_d = S_RUN;
                         else if (press_lap) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    logic run_en, tick, zero_cnt, capture;
    assign run_en   = (state_q == S_RUN) || (state_q == S_LAP);
    assign zero_cnt = clear || ((state_q == S_PAUSE) && press_lap);
    assign capture  = !clear && (state_q == S_RUN) && press_lap;

    // ------------------------------------------------------------------
    // Centisecond prescaler: frozen in PAUSE so a resume finishes the
    // partial centisecond; RUN<->LAP does not disturb it.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    assign tick = run_en && (presc_q == PRE_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc_q <= '0;
        end else if (zero_cnt || (state_q == S_IDLE) || tick) begin
            presc_q <= '0;
        end else if (run_en) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // BCD time counter {m10,m1,s10,s1,c10,c1}, one nibble per digit
    // ------------------------------------------------------------------
    logic [23:0] time_q, time_inc, lap_q;
    logic        carry;

    // Tens of seconds and tens of minutes stop at 5, every other digit at 9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    always_comb begin
        time_inc = time_q;
        carry    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (time_q[4*i +: 4] >= digit_max(i)) begin
                    time_inc[4*i +: 4] = 4'd0;
                end else begin
                    time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            time_q <= '0;
        end else if (zero_cnt) begin
            time_q <= '0;
        end else if (tick) begin
            time_q <= time_inc;
        end
    end

    // The lap register takes the value before any same-cycle increment.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lap_q <= '0;
        end else if (clear) begin
            lap_q <= '0;
        end else if (capture) begin
            lap_q <= time_q;
        end
    end

    // ------------------------------------------------------------------
    // Display and status registers
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic [23:0] disp_src;
    assign disp_src = (state_q == S_LAP) ? lap_q : time_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hex0       <= SEG_ZERO;
            hex1       <= SEG_ZERO;
            hex2       <= SEG_ZERO;
            hex3       <= SEG_ZERO;
            hex4       <= SEG_ZERO;
            hex5       <= SEG_ZERO;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            hex0       <= seg7(disp_src[3:0]);
            hex1       <= seg7(disp_src[7:4]);
            hex2       <= seg7(disp_src[11:8]);
            hex3       <= seg7(disp_src[15:12]);
            hex4       <= seg7(disp_src[19:16]);
            hex5       <= seg7(disp_src[23:20]);
            running    <= run_en;
            lap_active <= (state_q == S_LAP);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3.
//   Inputs change and outputs are sampled on the falling clock edge.
//   Comments of the form "E=n" give the number of rising edges since reset
//   was released at that sampling point.
module tb_stopwatch_ctrl;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       button_n;
    logic [1:0] sw;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       running, lap_active;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .TICK_DIV  (4),
        .DB_CYCLES (3)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .button_n      (button_n),
        .sw            (sw),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5),
        .running       (running),
        .lap_active    (lap_active)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    function automatic logic [6:0] seg_exp(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // bcd is {m10,m1,s10,s1,c10,c1}
    task automatic check_disp(input string tag, input logic [23:0] bcd);
        logic [41:0] expv, obs;
        expv = {seg_exp(bcd[23:20]), seg_exp(bcd[19:16]), seg_exp(bcd[15:12]),
                seg_exp(bcd[11:8]),  seg_exp(bcd[7:4]),   seg_exp(bcd[3:0])};
        obs  = {hex5, hex4, hex3, hex2, hex1, hex0};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed segs %h expected segs %h (time %h)",
                   tag, obs, expv, bcd);
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        button_n      = 1'b1;
        sw            = 2'b00;
        wait_cyc(2);
        check_disp("reset_hex", 24'h000000);
        check_bit("reset_running", running, 1'b0);
        check_bit("reset_lap", lap_active, 1'b0);

        // Start: press with sw=00. RUN at edge 7, a tick every 4 edges after.
        reset_reset_n = 1'b1;                 // E=0
        button_n = 1'b0;
        wait_cyc(8); button_n = 1'b1;         // E=8
        check_bit("start_running", running, 1'b1);
        check_bit("start_lap", lap_active, 1'b0);
        wait_cyc(399);                        // E=407
        check_disp("run_0099", 24'h000099);
        wait_cyc(1);                          // E=408
        check_disp("run_0100", 24'h000100);

        // Pause with one prescaler count elapsed, then resume.
        wait_cyc(1); button_n = 1'b0;         // E=409
        wait_cyc(8); button_n = 1'b1;         // E=417
        check_bit("pause_running", running, 1'b0);
        check_disp("pause_0102", 24'h000102);
        wait_cyc(100);                        // E=517
        check_disp("pause_frozen", 24'h000102);
        button_n = 1'b0;
        wait_cyc(8); button_n = 1'b1;         // E=525
        check_bit("resume_running", running, 1'b1);
        wait_cyc(2);                          // E=527
        check_disp("resume_pre_tick", 24'h000102);
        wait_cyc(1);                          // E=528
        check_disp("resume_tick", 24'h000103);

        // Lap press lands on a tick edge: lap holds 01.04, live goes on.
        sw = 2'b01; button_n = 1'b0;          // E=528
        wait_cyc(8); button_n = 1'b1;         // E=536
        check_bit("lap_active_on", lap_active, 1'b1);
        check_disp("lap_capture", 24'h000104);
        wait_cyc(40);                         // E=576
        check_disp("lap_frozen", 24'h000104);
        button_n = 1'b0;
        wait_cyc(8); button_n = 1'b1;         // E=584
        check_bit("lap_release", lap_active, 1'b0);
        check_disp("lap_live", 24'h000117);

        // Preload 59:59.99; the next tick is at edge 587.
        force dut.time_q = 24'h595999;
        #1 release dut.time_q;
        wait_cyc(3);                          // E=587
        check_disp("wrap_pre", 24'h595999);
        wait_cyc(1);                          // E=588
        check_disp("wrap_post", 24'h000000);

        // 2-cycle glitch with sw=01: no lap event.
        button_n = 1'b0;
        wait_cyc(2); button_n = 1'b1;         // E=590
        wait_cyc(10);                         // E=600
        check_bit("glitch_no_lap", lap_active, 1'b0);
        check_bit("glitch_running", running, 1'b1);

        // 3-cycle hold: exactly one lap event, capturing 00.04.
        button_n = 1'b0;
        wait_cyc(3); button_n = 1'b1;         // E=603
        wait_cyc(17);                         // E=620
        check_bit("hold_one_event", lap_active, 1'b1);
        check_disp("hold_lap_value", 24'h000004);
        button_n = 1'b0;
        wait_cyc(8); button_n = 1'b1;         // E=628
        check_bit("back_to_run", lap_active, 1'b0);

        // Hold-clear in RUN together with a press.
        wait_cyc(4);                          // E=632
        sw = 2'b11; button_n = 1'b0;
        wait_cyc(8); button_n = 1'b1;         // E=640
        check_bit("clear_running", running, 1'b0);
        check_bit("clear_lap", lap_active, 1'b0);
        check_disp("clear_hex", 24'h000000);
        wait_cyc(10); sw = 2'b00;             // E=650
        wait_cyc(10);                         // E=660
        check_bit("clear_stays_idle", running, 1'b0);
        check_disp("clear_stays_zero", 24'h000000);

        // press_lap in IDLE is ignored.
        sw = 2'b01; button_n = 1'b0;          // E=660
        wait_cyc(8); button_n = 1'b1;         // E=668
        check_bit("idle_ignores_lap", running, 1'b0);

        // Start, pause at 00.04, then press_lap returns to IDLE at zero.
        wait_cyc(6); sw = 2'b00; button_n = 1'b0;  // E=674
        wait_cyc(8); button_n = 1'b1;         // E=682
        check_bit("restart_running", running, 1'b1);
        wait_cyc(10); button_n = 1'b0;        // E=692
        wait_cyc(8); button_n = 1'b1;         // E=700
        check_bit("pause2_running", running, 1'b0);
        check_disp("pause2_value", 24'h000004);
        wait_cyc(4); sw = 2'b01; button_n = 1'b0;  // E=704
        wait_cyc(8); button_n = 1'b1;         // E=712
        check_disp("pause_lap_zero", 24'h000000);
        check_bit("pause_lap_idle", running, 1'b0);

        // Fresh start: first tick a full TICK_DIV after entering RUN.
        wait_cyc(8); sw = 2'b00; button_n = 1'b0;  // E=720
        wait_cyc(8); button_n = 1'b1;         // E=728
        wait_cyc(3);                          // E=731
        check_disp("fresh_pre_tick", 24'h000000);
        wait_cyc(1);                          // E=732
        check_disp("fresh_first_tick", 24'h000001);
        wait_cyc(4);                          // E=736
        check_disp("pre_reset_value", 24'h000002);
        check_bit("pre_reset_running", running, 1'b1);

        // Asynchronous reset between clock edges.
        #2 reset_reset_n = 1'b0;
        #1;
        check_disp("async_reset_hex", 24'h000000);
        check_bit("async_reset_running", running, 1'b0);
        check_bit("async_reset_lap", lap_active, 1'b0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        wait_cyc(10);
        check_bit("post_reset_idle", running, 1'b0);
        check_disp("post_reset_zero", 24'h000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
